// File: rtl/two_channel_arbiter_pkg.sv
// ============================================================================
// two_channel_arbiter_pkg
// Shared state encoding, channel IDs and default widths for the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package two_channel_arbiter_pkg;

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  localparam int DEF_N_BITS   = 8;
  localparam int DEF_CNT_BITS = 16;

endpackage

`default_nettype wire

// File: rtl/two_channel_arbiter_mux.sv
// ============================================================================
// Mux_Two_To_One
// Plain 2:1 word multiplexer; i_sel=0 picks i_data_0.
// Revision: 1.0
// ============================================================================
`default_nettype none

module Mux_Two_To_One #(
  parameter int WIDTH = 8
) (
  input  logic             i_sel,
  input  logic [WIDTH-1:0] i_data_0,
  input  logic [WIDTH-1:0] i_data_1,
  output logic [WIDTH-1:0] o_data
);

  assign o_data = i_sel ? i_data_1 : i_data_0;

endmodule

`default_nettype wire

// File: rtl/two_channel_arbiter.sv
// ============================================================================
// two_channel_arbiter
// Round-robin merge of two valid/ready channels into one output register.
// Optional macro ARB_BURST_LOCK_EN holds the grant until Last_x ends a burst.
// Revision: 1.0
// ============================================================================
`default_nettype none

module two_channel_arbiter
  import two_channel_arbiter_pkg::*;
#(
  parameter int N_BITS   = DEF_N_BITS,
  parameter int CNT_BITS = DEF_CNT_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                Valid_0,
  input  logic [N_BITS-1:0]   Data_0,
  input  logic                Last_0,
  output logic                Ready_0,
  input  logic                Valid_1,
  input  logic [N_BITS-1:0]   Data_1,
  input  logic                Last_1,
  output logic                Ready_1,
  output logic                Out_Valid,
  output logic [N_BITS-1:0]   Out_Data,
  output logic                Out_Channel,
  input  logic                Out_Ready,
  output logic [CNT_BITS-1:0] Xfer_Count
);

  state_t              r_state;
  state_t              w_state_next;
  logic                r_last_grant;
  logic                w_grant;
  logic                w_can_load;
  logic                w_accept;
  logic [N_BITS-1:0]   w_mux_data;
  logic [N_BITS-1:0]   r_out_data;
  logic                r_out_channel;
  logic [CNT_BITS-1:0] r_xfer_count;

`ifdef ARB_BURST_LOCK_EN
  logic r_lock;
  logic r_lock_ch;
  logic w_last;
  assign w_last = (w_grant == CH1) ? Last_1 : Last_0;
`else
  logic w_unused_last;
  assign w_unused_last = Last_0 | Last_1;
`endif

  always_comb begin
    w_grant = CH0;
    if (Valid_0 && Valid_1) begin
      w_grant = ~r_last_grant;
    end else if (Valid_1) begin
      w_grant = CH1;
    end
`ifdef ARB_BURST_LOCK_EN
    if (r_lock) begin
      w_grant = r_lock_ch;
    end
`endif
  end

  assign w_can_load = (r_state == EMPTY) || Out_Ready;
  assign Ready_0    = !reset && w_can_load && Valid_0 && (w_grant == CH0);
  assign Ready_1    = !reset && w_can_load && Valid_1 && (w_grant == CH1);
  assign w_accept   = Ready_0 || Ready_1;

  Mux_Two_To_One #(
    .WIDTH (N_BITS)
  ) u_mux (
    .i_sel    (w_grant),
    .i_data_0 (Data_0),
    .i_data_1 (Data_1),
    .o_data   (w_mux_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      EMPTY: if (w_accept) w_state_next = FULL;
      FULL: begin
        if (w_accept) begin
          w_state_next = FULL;
        end else if (Out_Ready) begin
          w_state_next = EMPTY;
        end
      end
      default: w_state_next = EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_out_data    <= '0;
      r_out_channel <= CH0;
    end else if (w_accept) begin
      r_out_data    <= w_mux_data;
      r_out_channel <= w_grant;
    end
  end

  // Pointer starts at CH1 so channel 0 wins the first contention.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last_grant <= CH1;
`ifdef ARB_BURST_LOCK_EN
      r_lock       <= 1'b0;
      r_lock_ch    <= CH0;
    end else if (w_accept) begin
      r_lock    <= !w_last;
      r_lock_ch <= w_grant;
      if (w_last) begin
        r_last_grant <= w_grant;
      end
`else
    end else if (w_accept) begin
      r_last_grant <= w_grant;
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_xfer_count <= '0;
    end else if (Out_Valid && Out_Ready) begin
      r_xfer_count <= r_xfer_count + CNT_BITS'(1);
    end
  end

  assign Out_Valid   = (r_state == FULL);
  assign Out_Data    = r_out_data;
  assign Out_Channel = r_out_channel;
  assign Xfer_Count  = r_xfer_count;

endmodule

`default_nettype wire

// File: doc/two_channel_arbiter.md
TWO_CHANNEL_ARBITER -- requirements
Module: two_channel_arbiter

Interface
REQ-001 The block SHALL have one clock, clk, and one reset, reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter N_BITS SHALL default to 8 and set the data-path width.
REQ-003 Parameter CNT_BITS SHALL default to 16 and set the transfer-counter width.
REQ-004 Ports SHALL be, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- Valid_0  in  1  channel 0 word present
- Data_0  in  N_BITS  channel 0 word
- Last_0  in  1  channel 0 burst end; used only under REQ-020
- Ready_0  out  1  channel 0 word accepted this cycle when Valid_0=1
- Valid_1  in  1  channel 1 word present
- Data_1  in  N_BITS  channel 1 word
- Last_1  in  1  channel 1 burst end; used only under REQ-020
- Ready_1  out  1  channel 1 word accepted this cycle when Valid_1=1
- Out_Valid  out  1  output register holds a word
- Out_Data  out  N_BITS  held word
- Out_Channel  out  1  source channel of held word
- Out_Ready  in  1  consumer takes the held word when Out_Valid=1
- Xfer_Count  out  CNT_BITS  count of words delivered to the consumer

Function
REQ-005 The output stage SHALL be a two-state machine: EMPTY (Out_Valid=0) and FULL (Out_Valid=1).
REQ-006 Can_Load SHALL be true in EMPTY, or in FULL when Out_Ready=1.
REQ-007 Grant SHALL be combinational:
- only Valid_0 high -> channel 0
- only Valid_1 high -> channel 1
- both high -> the channel not granted at the last accepted word
REQ-008 Ready_x SHALL be high only when Grant=x, Valid_x=1 and Can_Load; at most one Ready SHALL be high per cycle.
REQ-009 On acceptance, Out_Data, Out_Channel and the last-grant pointer SHALL load on the same edge, and the state SHALL be FULL the next cycle (latency 1 cycle).
REQ-010 FULL with Out_Ready=1 and no acceptance -> EMPTY; FULL with Out_Ready=1 and acceptance -> stay FULL with the new word (1 word/cycle sustained).
REQ-011 FULL with Out_Ready=0 SHALL hold Out_Data and Out_Channel stable, and both Ready outputs SHALL be 0.
REQ-012 Xfer_Count SHALL increment by 1 on every cycle with Out_Valid=1 and Out_Ready=1, and SHALL wrap from all-ones to 0.
REQ-013 With no Valid asserted, the state, the pointer and the held word SHALL NOT change, except for the drain defined in REQ-010.
REQ-014 The data select SHALL be Selector=Grant into a 2:1 multiplexer feeding the Out_Data register.

Reset
REQ-015 Reset SHALL force EMPTY, Out_Valid=0, Out_Data=0, Out_Channel=0 and Xfer_Count=0.
REQ-016 Reset SHALL set the last-grant pointer to channel 1, so channel 0 wins the first contention.
REQ-017 Ready_0 and Ready_1 SHALL be 0 in any cycle with reset=1.
REQ-018 Reset while in FULL SHALL discard the held word without counting it.
REQ-019 Reset SHALL clear any burst lock defined in REQ-020.

Configuration
REQ-020 With ARB_BURST_LOCK_EN defined:
- acceptance of a word with Last_x=0 SHALL lock Grant to channel x
- the lock SHALL persist, with the other channel's Ready held at 0, until a channel-x word with Last_x=1 is accepted
- the pointer SHALL update at burst end only
REQ-021 Without ARB_BURST_LOCK_EN, Last_0 and Last_1 SHALL be ignored and arbitration SHALL be per-word round-robin.

Structure
REQ-022 A shared package two_channel_arbiter_pkg SHALL hold:
- EMPTY/FULL state encoding
- channel ID constants CH0=0 and CH1=1
- default N_BITS and CNT_BITS
REQ-023 The block SHALL instantiate Mux_Two_To_One (N_BITS wide) as its single sub-module for the data select.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- Reset release, Valid_0=1 Data_0=8'hA5, Out_Ready=1 -> Ready_0=1 in cycle 0; Out_Valid=1, Out_Data=A5, Out_Channel=0 in cycle 1; Xfer_Count=1 after the drain.
- Both Valid high for 4 cycles, Out_Ready=1 -> Out_Channel sequence 0,1,0,1 and 1 word/cycle.
- FULL, Out_Ready=0 for 3 cycles with both Valid high -> Ready_0=Ready_1=0; Out_Data stable; Xfer_Count unchanged.
- Preload Xfer_Count to 16'hFFFF via 65535 transfers, then one more transfer -> Xfer_Count=0.
- Reset pulse while FULL holding 8'h3C -> next cycle Out_Valid=0, Xfer_Count=0, and the word is not delivered.
- ARB_BURST_LOCK_EN defined: channel 0 sends 3 words with Last_0 high on the third, Valid_1 held high -> Ready_1=0 for all 3 words; channel 1 is granted next.
